// File: rtl/seg_display_scan.sv
// Time-multiplexed driver for a common-anode 7-segment display. The value is
// double-buffered so a newly loaded value only takes effect at a frame boundary.
module seg_display_scan #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 50000,
    parameter int BLANK  = 2
) (
    input  logic                  IN_clk,
    input  logic                  IN_reset,
    input  logic [4*DIGITS-1:0]   IN_value,
    input  logic [DIGITS-1:0]     IN_dp,
    input  logic                  IN_blank_lz,
    input  logic                  IN_load,
    output logic [DIGITS-1:0]     OUT_dig,
    output logic [6:0]            OUT_seg,
    output logic                  OUT_dp,
    output logic                  OUT_pending,
    output logic                  OUT_frame
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    disp_val_q, disp_val_d;
    logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic                   disp_lz_q, disp_lz_d;
    logic [4*DIGITS-1:0]    sh_val_q, sh_val_d;
    logic [DIGITS-1:0]      sh_dp_q, sh_dp_d;
    logic                   sh_lz_q, sh_lz_d;
    logic                   pending_q, pending_d;
    logic                   frame_q, frame_d;
    logic [DIGITS-1:0]      dig_q, dig_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic [3:0]             nibble_arr [DIGITS];
    logic [DIGITS-1:0]      lz_blank;
    logic [DIGITS-1:0]      dig_onehot_n;
    logic                   boundary;
    logic                   in_gap;
    logic                   cur_blank;

    function automatic logic [6:0] seg_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero;
    // the rightmost digit is always lit so a zero value still shows "0".
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble_arr[gi]   = disp_val_q[4*gi +: 4];
            assign dig_onehot_n[gi] = (idx_q != IW'(gi));
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = disp_lz_q && (disp_val_q[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        boundary   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        in_gap     = (cnt_q < CNT_BLANK);
        cur_blank  = lz_blank[idx_q];

        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_lz_d  = disp_lz_q;
        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_lz_d    = sh_lz_q;
        pending_d  = pending_q;

        // Commit uses the shadow as it stood before this edge, so a load landing
        // on the boundary edge is queued for the following frame.
        if (boundary && pending_q) begin
            disp_val_d = sh_val_q;
            disp_dp_d  = sh_dp_q;
            disp_lz_d  = sh_lz_q;
            pending_d  = 1'b0;
        end
        if (IN_load) begin
            sh_val_d  = IN_value;
            sh_dp_d   = IN_dp;
            sh_lz_d   = IN_blank_lz;
            pending_d = 1'b1;
        end

        frame_d = boundary;
        dig_d   = (in_gap || cur_blank) ? '1 : dig_onehot_n;
        seg_d   = cur_blank ? 7'h7F : ~seg_hex(nibble_arr[idx_q]);
        dp_d    = (in_gap || cur_blank) ? 1'b1 : ~disp_dp_q[idx_q];
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_lz_q  <= 1'b0;
            sh_val_q   <= '0;
            sh_dp_q    <= '0;
            sh_lz_q    <= 1'b0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            dig_q      <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_lz_q  <= disp_lz_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            sh_lz_q    <= sh_lz_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign OUT_dig     = dig_q;
    assign OUT_seg     = seg_q;
    assign OUT_dp      = dp_q;
    assign OUT_pending = pending_q;
    assign OUT_frame   = frame_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: a cycle-position model of the scan
// predicts every output cycle; a monitor compares the DUT against the queue.
module tb_seg_display_scan;

    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * DWELL;

    logic        clk = 1'b0;
    logic        IN_reset = 1'b1;
    logic [15:0] IN_value = '0;
    logic [3:0]  IN_dp = '0;
    logic        IN_blank_lz = 1'b0;
    logic        IN_load = 1'b0;
    logic [3:0]  OUT_dig;
    logic [6:0]  OUT_seg;
    logic        OUT_dp;
    logic        OUT_pending;
    logic        OUT_frame;

    always #5 clk = ~clk;

    seg_display_scan #(.DIGITS(4), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .IN_clk      (clk),
        .IN_reset    (IN_reset),
        .IN_value    (IN_value),
        .IN_dp       (IN_dp),
        .IN_blank_lz (IN_blank_lz),
        .IN_load     (IN_load),
        .OUT_dig     (OUT_dig),
        .OUT_seg     (OUT_seg),
        .OUT_dp      (OUT_dp),
        .OUT_pending (OUT_pending),
        .OUT_frame   (OUT_frame)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        logic       frame;
    } obs_t;

    obs_t exp_q[$];
    int   tag_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle_no = 0;

    // Active-high {g..a} hex patterns, indexed by nibble value.
    logic [6:0] hex_seg [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    // Reference state: position in the scan counted in cycles since reset release.
    int          m_n = 0;
    logic [15:0] m_val = '0, m_sh_val = '0;
    logic [3:0]  m_dp = '0, m_sh_dp = '0;
    logic        m_lz = 1'b0, m_sh_lz = 1'b0, m_pend = 1'b0;

    function automatic obs_t model_view(input int n);
        obs_t        o;
        int          p, d, off;
        logic [15:0] upper;
        logic        blanked, gap;
        p       = n % FRAME;
        d       = p / DWELL;
        off     = p % DWELL;
        upper   = m_val >> (4 * d);
        blanked = m_lz && (d > 0) && (upper == 16'h0);
        gap     = (off < BLANK);
        o.dig   = (gap || blanked) ? 4'hF : ~(4'b0001 << d);
        o.seg   = blanked ? 7'h7F : ~hex_seg[upper[3:0]];
        o.dp    = (gap || blanked) ? 1'b1 : ~m_dp[d];
        o.pend  = 1'b0;
        o.frame = 1'b0;
        return o;
    endfunction

    task automatic cycle(input logic rst, input logic ld, input logic [15:0] v,
                         input logic [3:0] dpv, input logic lz);
        obs_t e;
        logic bnd;
        @(negedge clk);
        IN_reset    = rst;
        IN_load     = ld;
        IN_value    = v;
        IN_dp       = dpv;
        IN_blank_lz = lz;
        if (rst) begin
            m_n = 0; m_val = '0; m_sh_val = '0; m_dp = '0; m_sh_dp = '0;
            m_lz = 1'b0; m_sh_lz = 1'b0; m_pend = 1'b0;
            e.dig = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.pend = 1'b0; e.frame = 1'b0;
        end else begin
            e   = model_view(m_n);
            bnd = ((m_n % FRAME) == FRAME - 1);
            if (bnd && m_pend) begin
                m_val = m_sh_val; m_dp = m_sh_dp; m_lz = m_sh_lz; m_pend = 1'b0;
            end
            if (ld) begin
                m_sh_val = v; m_sh_dp = dpv; m_sh_lz = lz; m_pend = 1'b1;
                $display("[TB] cyc %0d load value=%h dp=%b blank_lz=%b phase=%0d",
                         cycle_no, v, dpv, lz, m_n % FRAME);
            end
            e.pend  = m_pend;
            e.frame = bnd;
            m_n++;
        end
        exp_q.push_back(e);
        tag_q.push_back(cycle_no);
        cycle_no++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic wait_phase(input int target);
        for (int k = 0; k < FRAME; k++) begin
            if ((m_n % FRAME) == target) break;
            idle(1);
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
        cycle(1'b0, 1'b1, v, dpv, lz);
    endtask

    // Monitor: one expected observation per clock edge.
    initial begin : monitor
        obs_t e, got;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {OUT_dig, OUT_seg, OUT_dp, OUT_pending, OUT_frame};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL scan_cyc%0d: got dig=%b seg=%b dp=%b pend=%b frame=%b, expected dig=%b seg=%b dp=%b pend=%b frame=%b",
                             t, got.dig, got.seg, got.dp, got.pend, got.frame,
                             e.dig, e.seg, e.dp, e.pend, e.frame);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        logic [15:0] v;

        repeat (3) cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(40);                                   // free run showing 0

        wait_phase(5);                              // mid-frame load at digit 1
        load(16'h12AF, 4'b0000, 1'b0);
        idle(40);

        wait_phase(2);                              // two loads in one frame
        load(16'h1111, 4'b0000, 1'b0);
        idle(3);
        load(16'h2222, 4'b0010, 1'b0);
        idle(40);

        wait_phase(3);                              // load on the boundary edge
        load(16'h0005, 4'b0000, 1'b0);
        wait_phase(FRAME - 1);
        load(16'h0009, 4'b0001, 1'b0);
        idle(40);

        load(16'h0040, 4'b0000, 1'b1);              // leading-zero blanking
        idle(40);
        load(16'h0000, 4'b1111, 1'b1);
        idle(40);

        load(16'hABCD, 4'b0101, 1'b0);
        idle(36);
        wait_phase(8);                              // reset mid-dwell with pending
        load(16'h7777, 4'b1111, 1'b0);
        cycle(1'b1, 1'b1, 16'h3333, 4'b1111, 1'b0);
        idle(24);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cycle(1'b1, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
            end else if (r < 12) begin
                v = 16'($urandom);
                if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
                load(v, 4'($urandom), 1'($urandom));
            end else begin
                idle(1);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d observations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
